energy_accumulator: RTL
=======================

ENERGY_ACCUMULATOR -- requirements
Module: energy_accumulator

Interface
REQ-001 SHALL have parameter PARALLELISM, default 4: partial-energy lanes per beat, equal to the spin step size of the downstream index counter.
REQ-002 SHALL have parameter COUNTER_BITWIDTH, default 8: width of the step target and step index.
REQ-003 SHALL have parameter PARTIAL_BITWIDTH, default 16: signed width of one partial-energy lane.
REQ-004 SHALL have parameter ENERGY_BITWIDTH, default 32: signed width of the accumulated energy.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port en_i, input, 1 bit: module enable; when low, all state is frozen and partial_ready_o is low.
REQ-008 SHALL have port config_valid_i, input, 1 bit: load strobe for the step target.
REQ-009 SHALL have port config_target_i, input, COUNTER_BITWIDTH bits: last spin index, unsigned.
REQ-010 SHALL have port start_i, input, 1 bit: begin one accumulation run.
REQ-011 SHALL have port partial_valid_i, input, 1 bit: upstream beat valid.
REQ-012 SHALL have port partial_ready_o, output, 1 bit: beat accepted when valid and ready are both high.
REQ-013 SHALL have port partial_i, input, PARALLELISM*PARTIAL_BITWIDTH bits: signed lanes; lane k occupies bits [k*PARTIAL_BITWIDTH +: PARTIAL_BITWIDTH].
REQ-014 SHALL have port step_idx_o, output, COUNTER_BITWIDTH bits: spin index of the beat expected next.
REQ-015 SHALL have port energy_valid_o, output, 1 bit: result valid.
REQ-016 SHALL have port energy_ready_i, input, 1 bit: downstream accepts the result.
REQ-017 SHALL have port energy_o, output, ENERGY_BITWIDTH bits: signed accumulated energy.
REQ-018 SHALL have port overflow_o, output, 1 bit: sticky saturation flag for the current run.
REQ-019 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-020 SHALL implement an FSM with states IDLE, ACCUM and DONE; when en_i is low, no transition occurs and no register updates.
REQ-021 SHALL load the target register from config_target_i when en_i and config_valid_i are high in IDLE, and SHALL ignore config_valid_i in all other states.
REQ-022 SHALL move from IDLE to ACCUM on en_i and start_i, clearing the accumulator, step_idx_o and overflow_o in that same cycle.
REQ-023 SHALL ignore start_i in ACCUM and DONE.
REQ-024 SHALL drive partial_ready_o as (state == ACCUM) AND en_i, combinationally.
REQ-025 SHALL, on each accepted beat: sign-extend and sum all lanes in PARTIAL_BITWIDTH+$clog2(PARALLELISM) bits; add the sum to the accumulator in ENERGY_BITWIDTH+1 bits; then increment step_idx_o by PARALLELISM.
REQ-026 SHALL saturate the accumulator to +(2^(ENERGY_BITWIDTH-1))-1 or -(2^(ENERGY_BITWIDTH-1)) on overflow and set overflow_o, which then stays high until the next start.
REQ-027 SHALL treat a beat as the last when step_idx_o + PARALLELISM > target, with the comparison done in COUNTER_BITWIDTH+1 bits so that no wrap-around occurs; on the last beat the FSM SHALL go to DONE.
REQ-028 SHALL therefore accept exactly floor(target/PARALLELISM)+1 beats per run.
REQ-029 SHALL in DONE drive energy_valid_o high and energy_o equal to the accumulator register; energy_o and energy_valid_o are registered, with result available 1 cycle after the last beat.
REQ-030 SHALL hold energy_o stable while energy_valid_o is high and energy_ready_i is low.
REQ-031 SHALL return to IDLE on energy_valid_o AND energy_ready_i, keeping energy_o at its last value.
REQ-032 SHALL let the accumulator, step_idx_o and overflow_o change only as given in REQ-022, REQ-025 and REQ-026.

Reset
REQ-033 SHALL, on rst_ni low, asynchronously set: state to IDLE; accumulator/energy_o to 0; step_idx_o to 0; overflow_o, energy_valid_o and busy_o to 0; target to all ones.
REQ-034 SHALL, on reset during ACCUM or DONE, discard the run; after release, the next start_i begins a clean run.

Verification
REQ-035 SHALL cover: P=4, target=15, 4 beats with all lanes =1 -> energy_o=16, valid 1 cycle after beat 4, step_idx_o sequence 0,4,8,12,16.
REQ-036 SHALL cover: target=5, lanes {-3,2,0,1} per beat -> exactly 2 beats accepted, energy_o=0, third valid beat not accepted (ready low).
REQ-037 SHALL cover: partial_valid_i toggling and en_i low for 3 cycles mid-run -> result identical to an uninterrupted run, no beat lost or duplicated.
REQ-038 SHALL cover: energy_ready_i held low for 10 cycles in DONE -> energy_o stable and start_i ignored; IDLE after the handshake.
REQ-039 SHALL cover: ENERGY_BITWIDTH=16 with lanes =0x7FFF -> energy_o=32767 and overflow_o=1 until the next start.
REQ-040 SHALL cover: reset after the 2nd beat of a run -> all outputs zero; a new run with target 7 produces the correct sum.

Source files
------------

// File: rtl/energy_accumulator.sv
// Energy accumulator: sums signed partial-energy beats into a saturating
// total, one run per start, handing the result off with a valid/ready pair.
module energy_accumulator #(
  parameter int PARALLELISM      = 4,
  parameter int COUNTER_BITWIDTH = 8,
  parameter int PARTIAL_BITWIDTH = 16,
  parameter int ENERGY_BITWIDTH  = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     en_i,
  input  logic                                     config_valid_i,
  input  logic [COUNTER_BITWIDTH-1:0]              config_target_i,
  input  logic                                     start_i,
  input  logic                                     partial_valid_i,
  output logic                                     partial_ready_o,
  input  logic [PARALLELISM*PARTIAL_BITWIDTH-1:0]  partial_i,
  output logic [COUNTER_BITWIDTH-1:0]              step_idx_o,
  output logic                                     energy_valid_o,
  input  logic                                     energy_ready_i,
  output logic [ENERGY_BITWIDTH-1:0]               energy_o,
  output logic                                     overflow_o,
  output logic                                     busy_o
);

  localparam int P  = PARALLELISM;
  localparam int C  = COUNTER_BITWIDTH;
  localparam int PW = PARTIAL_BITWIDTH;
  localparam int E  = ENERGY_BITWIDTH;
  localparam int SW = PW + $clog2(P);
  localparam int CW = C + 1;
  // Add width must also hold the full lane sum when it is wider than E.
  localparam int AW = ((E > SW) ? E : SW) + 1;

  localparam logic signed [E-1:0] E_MAX = {1'b0, {(E-1){1'b1}}};
  localparam logic signed [E-1:0] E_MIN = {1'b1, {(E-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [C-1:0]         r_target;
  logic [C-1:0]         r_step;
  logic signed [E-1:0]  r_acc;
  logic signed [E-1:0]  r_energy;
  logic                 r_ovf;
  logic                 r_evalid;

  logic signed [SW-1:0] w_lane_sum;
  logic signed [AW-1:0] w_acc_wide;
  logic [AW-E:0]        w_hi;
  logic                 w_ovf;
  logic signed [E-1:0]  w_acc_sat;
  logic [C-1:0]         w_step_nxt;
  logic                 w_last;

  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < P; k++) begin
      w_lane_sum = w_lane_sum
                 + SW'($signed(partial_i[k*PW +: PW]));
    end
  end

  assign w_acc_wide = AW'(r_acc) + AW'(w_lane_sum);
  assign w_hi       = w_acc_wide[AW-1:E-1];
  assign w_ovf      = !((&w_hi) || (~|w_hi));

  always_comb begin
    w_acc_sat = w_acc_wide[E-1:0];
    if (w_ovf) begin
      w_acc_sat = w_acc_wide[AW-1] ? E_MIN : E_MAX;
    end
  end

  assign w_step_nxt = r_step + C'(P);
  assign w_last     = ({1'b0, r_step} + CW'(P))
                    > {1'b0, r_target};

  assign partial_ready_o = (r_state == ACCUM) && en_i;
  assign step_idx_o      = r_step;
  assign energy_valid_o  = r_evalid;
  assign energy_o        = r_energy;
  assign overflow_o      = r_ovf;
  assign busy_o          = (r_state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_target <= '1;
      r_step   <= '0;
      r_acc    <= '0;
      r_energy <= '0;
      r_ovf    <= 1'b0;
      r_evalid <= 1'b0;
    end else if (en_i) begin
      case (r_state)
        IDLE: begin
          if (config_valid_i) begin
            r_target <= config_target_i;
          end
          if (start_i) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_step  <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (partial_valid_i) begin
            r_acc  <= w_acc_sat;
            r_step <= w_step_nxt;
            if (w_ovf) begin
              r_ovf <= 1'b1;
            end
            if (w_last) begin
              r_state  <= DONE;
              r_energy <= w_acc_sat;
              r_evalid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (energy_ready_i) begin
            r_state  <= IDLE;
            r_evalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_evalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
